// File: rtl/raygen_seq_pkg.sv
// Shared types and constants for the raygen handshake sequencer.
// Host FSM states, the host grant encoding, the result-source codes and
// the depth of the result queue all live here.
package raygen_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    ACK,
    HOLD,
    READ
  } host_state_t;

  typedef enum logic [1:0] {
    GNT_ADDR,
    GNT_DATA,
    GNT_CFG
  } grant_t;

  localparam logic [1:0] SRC_01   = 2'd1;
  localparam logic [1:0] SRC_10   = 2'd2;
  localparam logic [2:0] PEND_MAX = 3'd4;

  // Fixed-priority host grant: address beats data, data beats config.
  // Only meaningful while at least one want is asserted.
  function automatic grant_t pick_grant(input logic want_addr, input logic want_data);
    if (want_addr) begin
      return GNT_ADDR;
    end
    if (want_data) begin
      return GNT_DATA;
    end
    return GNT_CFG;
  endfunction

endpackage

// File: rtl/raygen_busy_emul.sv
// Emulates one ray-group consumer: takes a group when it is offered and the
// consumer is free, then reports busy for exactly BUSY_CYCLES cycles.
// Offers that arrive while busy are ignored.
module raygen_busy_emul #(
  parameter int BUSY_CYCLES = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic offer,
  output logic busy
);

  localparam int CW = (BUSY_CYCLES > 1) ? $clog2(BUSY_CYCLES) : 1;

  logic          busy_q, busy_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Accept on a free offer, then count the busy window down to zero.
  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    if (!busy_q) begin
      if (offer) begin
        busy_d = 1'b1;
        cnt_d  = CW'(BUSY_CYCLES - 1);
      end
    end else if (cnt_q == '0) begin
      busy_d = 1'b0;
    end else begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  // Busy flag and window counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy = busy_q;

endmodule

// File: rtl/raygen_handshake_sequencer.sv
// Environment controller that answers every handshake of the raygen core:
// host address/data/config acks, periodic host reads, two ray-group
// consumers, the tracer result queue and framebuffer scanline advance.
// Build option: define RAYGEN_SEQ_JITTER_EN to add 0..3 cycles of
// LFSR-driven jitter to each host ack latency.
module raygen_handshake_sequencer
  import raygen_seq_pkg::*;
#(
  parameter int ACK_LATENCY    = 3,
  parameter int READ_PERIOD    = 64,
  parameter int BUSY_CYCLES    = 8,
  parameter int RESULT_LATENCY = 12,
  parameter int LINE_WORDS     = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rgwant_addr,
  input  logic       rgwant_data,
  input  logic       rgwant_CfgData,
  input  logic       rgread_ready,
  output logic       rgaddr_ready,
  output logic       rgdata_ready,
  output logic       rgCfgData_ready,
  output logic       rgwant_read,
  input  logic       raygroupvalid01,
  input  logic       raygroupvalid10,
  output logic       busy01,
  output logic       busy10,
  input  logic       rgAddrValid,
  output logic       rgResultReady,
  output logic [1:0] rgResultSource,
  output logic       rgDone,
  input  logic       fbdatavalid,
  output logic       fbnextscanline,
  output logic       result_ovf
);

  localparam int LAT_W  = $clog2(ACK_LATENCY + 4);
  localparam int IDLE_W = $clog2(READ_PERIOD + 1);
  localparam int TMR_W  = $clog2(RESULT_LATENCY + 1);
  localparam int BEAT_W = $clog2(LINE_WORDS + 1);

  host_state_t       state_q, state_d;
  grant_t            grant_q, grant_d;
  logic [LAT_W-1:0]  lat_q, lat_d, lat_load;
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic              addr_rdy_q, addr_rdy_d;
  logic              data_rdy_q, data_rdy_d;
  logic              cfg_rdy_q, cfg_rdy_d;
  logic              want_read_q, want_read_d;
  logic              granted_want;

  logic [2:0]        pend_q, pend_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic              tmr_act_q, tmr_act_d;
  logic              res_rdy_q, res_rdy_d;
  logic [1:0]        src_q, src_d;
  logic              ovf_q, ovf_d;
  logic              done_q, done_d;
  logic              load_now, accept;

  logic [BEAT_W-1:0] beat_q, beat_d;
  logic              scan_q, scan_d;

`ifdef RAYGEN_SEQ_JITTER_EN
  logic [7:0] lfsr_q, lfsr_d;

  // Free-running x^8+x^6+x^5+x^4+1 Fibonacci LFSR supplying latency jitter.
  always_comb begin
    lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  // LFSR register, reseeded on reset so runs are reproducible.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lfsr_q <= 8'hA5;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign lat_load = LAT_W'(ACK_LATENCY - 1) + LAT_W'(lfsr_q[1:0]);
`else
  assign lat_load = LAT_W'(ACK_LATENCY - 1);
`endif

  // The want belonging to the current grant decides when HOLD may release.
  always_comb begin
    unique case (grant_q)
      GNT_ADDR: granted_want = rgwant_addr;
      GNT_DATA: granted_want = rgwant_data;
      default:  granted_want = rgwant_CfgData;
    endcase
  end

  // Host FSM: grant a want, wait out the latency, pulse one ack, then hold
  // until the want drops; with nothing to do for a while, issue a host read.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    lat_d       = lat_q;
    idle_d      = idle_q;
    addr_rdy_d  = 1'b0;
    data_rdy_d  = 1'b0;
    cfg_rdy_d   = 1'b0;
    want_read_d = want_read_q;
    unique case (state_q)
      IDLE: begin
        if (rgwant_addr || rgwant_data || rgwant_CfgData) begin
          grant_d = pick_grant(rgwant_addr, rgwant_data);
          lat_d   = lat_load;
          idle_d  = '0;
          state_d = WAIT;
        end else if (idle_q == IDLE_W'(READ_PERIOD - 1)) begin
          idle_d      = '0;
          want_read_d = 1'b1;
          state_d     = READ;
        end else begin
          idle_d = idle_q + IDLE_W'(1);
        end
      end
      WAIT: begin
        if (lat_q == '0) begin
          state_d = ACK;
          unique case (grant_q)
            GNT_ADDR: addr_rdy_d = 1'b1;
            GNT_DATA: data_rdy_d = 1'b1;
            default:  cfg_rdy_d  = 1'b1;
          endcase
        end else begin
          lat_d = lat_q - LAT_W'(1);
        end
      end
      ACK: begin
        state_d = HOLD;
      end
      HOLD: begin
        if (!granted_want) begin
          state_d = IDLE;
        end
      end
      READ: begin
        if (rgread_ready) begin
          want_read_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Host FSM state and its registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      grant_q     <= GNT_ADDR;
      lat_q       <= '0;
      idle_q      <= '0;
      addr_rdy_q  <= 1'b0;
      data_rdy_q  <= 1'b0;
      cfg_rdy_q   <= 1'b0;
      want_read_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      lat_q       <= lat_d;
      idle_q      <= idle_d;
      addr_rdy_q  <= addr_rdy_d;
      data_rdy_q  <= data_rdy_d;
      cfg_rdy_q   <= cfg_rdy_d;
      want_read_q <= want_read_d;
    end
  end

  // Result scheduler: the timer pulls one queued result at a time, so the
  // queue of four plus the one in flight bounds accepted results at five.
  always_comb begin
    load_now  = (pend_q != '0) && !tmr_act_q;
    accept    = rgAddrValid && ((pend_q != PEND_MAX) || load_now);
    pend_d    = pend_q;
    tmr_d     = tmr_q;
    tmr_act_d = tmr_act_q;
    res_rdy_d = 1'b0;
    src_d     = src_q;
    ovf_d     = ovf_q | (rgAddrValid && !accept);
    done_d    = (pend_q == '0) && !tmr_act_q && !busy01 && !busy10;
    if (accept && !load_now) begin
      pend_d = pend_q + 3'd1;
    end else if (!accept && load_now) begin
      pend_d = pend_q - 3'd1;
    end
    if (load_now) begin
      tmr_act_d = 1'b1;
      tmr_d     = TMR_W'(RESULT_LATENCY - 1);
    end else if (tmr_act_q) begin
      if (tmr_q == '0) begin
        tmr_act_d = 1'b0;
        res_rdy_d = 1'b1;
      end else begin
        tmr_d = tmr_q - TMR_W'(1);
      end
    end
    if (res_rdy_q) begin
      src_d = (src_q == SRC_01) ? SRC_10 : SRC_01;
    end
  end

  // Result scheduler and idle-indicator registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_q    <= '0;
      tmr_q     <= '0;
      tmr_act_q <= 1'b0;
      res_rdy_q <= 1'b0;
      src_q     <= SRC_01;
      ovf_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      pend_q    <= pend_d;
      tmr_q     <= tmr_d;
      tmr_act_q <= tmr_act_d;
      res_rdy_q <= res_rdy_d;
      src_q     <= src_d;
      ovf_q     <= ovf_d;
      done_q    <= done_d;
    end
  end

  // Framebuffer beat counter; the last beat of a line requests the next one.
  always_comb begin
    beat_d = beat_q;
    scan_d = 1'b0;
    if (fbdatavalid) begin
      if (beat_q == BEAT_W'(LINE_WORDS - 1)) begin
        beat_d = '0;
        scan_d = 1'b1;
      end else begin
        beat_d = beat_q + BEAT_W'(1);
      end
    end
  end

  // Framebuffer counter and scanline pulse registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      beat_q <= '0;
      scan_q <= 1'b0;
    end else begin
      beat_q <= beat_d;
      scan_q <= scan_d;
    end
  end

  raygen_busy_emul #(
    .BUSY_CYCLES(BUSY_CYCLES)
  ) u_busy01 (
    .clk  (clk),
    .reset(reset),
    .offer(raygroupvalid01),
    .busy (busy01)
  );

  raygen_busy_emul #(
    .BUSY_CYCLES(BUSY_CYCLES)
  ) u_busy10 (
    .clk  (clk),
    .reset(reset),
    .offer(raygroupvalid10),
    .busy (busy10)
  );

  assign rgaddr_ready    = addr_rdy_q;
  assign rgdata_ready    = data_rdy_q;
  assign rgCfgData_ready = cfg_rdy_q;
  assign rgwant_read     = want_read_q;
  assign rgResultReady   = res_rdy_q;
  assign rgResultSource  = src_q;
  assign rgDone          = done_q;
  assign fbnextscanline  = scan_q;
  assign result_ovf      = ovf_q;

endmodule

// File: tb/tb_raygen_handshake_sequencer.sv
// Directed bench for raygen_handshake_sequencer with default parameters.
// Expected cycle counts below are worked out by hand from the behaviour.
module tb_raygen_handshake_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rgwant_addr = 1'b0;
  logic       rgwant_data = 1'b0;
  logic       rgwant_CfgData = 1'b0;
  logic       rgread_ready = 1'b0;
  logic       rgaddr_ready;
  logic       rgdata_ready;
  logic       rgCfgData_ready;
  logic       rgwant_read;
  logic       raygroupvalid01 = 1'b0;
  logic       raygroupvalid10 = 1'b0;
  logic       busy01;
  logic       busy10;
  logic       rgAddrValid = 1'b0;
  logic       rgResultReady;
  logic [1:0] rgResultSource;
  logic       rgDone;
  logic       fbdatavalid = 1'b0;
  logic       fbnextscanline;
  logic       result_ovf;

  int checks = 0;
  int errors = 0;
  int addrCnt, dataCnt, cfgCnt, resCnt, scanCnt;
  logic [1:0] srcLog [16];

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  raygen_handshake_sequencer dut (
    .clk            (clk),
    .reset          (reset),
    .rgwant_addr    (rgwant_addr),
    .rgwant_data    (rgwant_data),
    .rgwant_CfgData (rgwant_CfgData),
    .rgread_ready   (rgread_ready),
    .rgaddr_ready   (rgaddr_ready),
    .rgdata_ready   (rgdata_ready),
    .rgCfgData_ready(rgCfgData_ready),
    .rgwant_read    (rgwant_read),
    .raygroupvalid01(raygroupvalid01),
    .raygroupvalid10(raygroupvalid10),
    .busy01         (busy01),
    .busy10         (busy10),
    .rgAddrValid    (rgAddrValid),
    .rgResultReady  (rgResultReady),
    .rgResultSource (rgResultSource),
    .rgDone         (rgDone),
    .fbdatavalid    (fbdatavalid),
    .fbnextscanline (fbnextscanline),
    .result_ovf     (result_ovf)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic addr, input logic data, input logic cfg, input logic rdRdy,
                               input logic v01, input logic v10, input logic av, input logic fb);
    rgwant_addr     = addr;
    rgwant_data     = data;
    rgwant_CfgData  = cfg;
    rgread_ready    = rdRdy;
    raygroupvalid01 = v01;
    raygroupvalid10 = v10;
    rgAddrValid     = av;
    fbdatavalid     = fb;
  endtask

  task automatic clearCounts();
    addrCnt = 0;
    dataCnt = 0;
    cfgCnt  = 0;
    resCnt  = 0;
    scanCnt = 0;
  endtask

  // One clock: sample 1 ns after the rising edge and tally output pulses.
  task automatic tick();
    @(posedge clk);
    #1;
    if (rgaddr_ready)    addrCnt++;
    if (rgdata_ready)    dataCnt++;
    if (rgCfgData_ready) cfgCnt++;
    if (fbnextscanline)  scanCnt++;
    if (rgResultReady) begin
      if (resCnt < 16) srcLog[resCnt] = rgResultSource;
      resCnt++;
    end
  endtask

  // Pulls reset low just after an edge with all inputs idle.
  task automatic assertReset();
    @(posedge clk);
    #1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    clearCounts();
    #2;
  endtask

  task automatic checkAllIdle(input string tag);
    checkOutput({tag, "_addr_ready"}, 32'(rgaddr_ready), 32'd0);
    checkOutput({tag, "_data_ready"}, 32'(rgdata_ready), 32'd0);
    checkOutput({tag, "_cfg_ready"},  32'(rgCfgData_ready), 32'd0);
    checkOutput({tag, "_want_read"},  32'(rgwant_read), 32'd0);
    checkOutput({tag, "_busy"},       32'({busy01, busy10}), 32'd0);
    checkOutput({tag, "_result"},     32'(rgResultReady), 32'd0);
    checkOutput({tag, "_source"},     32'(rgResultSource), 32'd1);
    checkOutput({tag, "_done"},       32'(rgDone), 32'd0);
    checkOutput({tag, "_scan"},       32'(fbnextscanline), 32'd0);
    checkOutput({tag, "_ovf"},        32'(result_ovf), 32'd0);
  endtask

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios, each starting from a fresh reset.
  initial begin
    clearCounts();

    // Reset values, then addr+data raised together: addr wins after 4 cycles.
    assertReset();
    checkAllIdle("rst");
    #2 reset = 1'b1;
    applyStimulus(1, 1, 0, 0, 0, 0, 0, 0);
    repeat (3) tick();
    checkOutput("addr_ready_early", 32'(rgaddr_ready), 32'd0);
    tick();
    checkOutput("addr_ready_pulse", 32'(rgaddr_ready), 32'd1);
    checkOutput("data_ready_blocked", 32'(rgdata_ready), 32'd0);
    tick();
    checkOutput("addr_ready_width", 32'(rgaddr_ready), 32'd0);
    repeat (10) tick();
    checkOutput("addr_pulse_count", 32'(addrCnt), 32'd1);
    checkOutput("data_pulse_in_hold", 32'(dataCnt), 32'd0);
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);
    repeat (4) tick();
    checkOutput("data_ready_early", 32'(dataCnt), 32'd0);
    tick();
    checkOutput("data_ready_pulse", 32'(rgdata_ready), 32'd1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (5) tick();
    checkOutput("data_pulse_count", 32'(dataCnt), 32'd1);
    checkOutput("addr_pulse_total", 32'(addrCnt), 32'd1);

    // Config want held 50 cycles gets a single ack, none after the drop.
    assertReset();
    #2 reset = 1'b1;
    applyStimulus(0, 0, 1, 0, 0, 0, 0, 0);
    repeat (50) tick();
    checkOutput("cfg_pulse_held", 32'(cfgCnt), 32'd1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (10) tick();
    checkOutput("cfg_pulse_after_drop", 32'(cfgCnt), 32'd1);
    checkOutput("cfg_no_other_acks", 32'(addrCnt + dataCnt), 32'd0);

    // 64 idle cycles raise the host read; read-complete drops it next cycle.
    assertReset();
    #2 reset = 1'b1;
    repeat (63) tick();
    checkOutput("read_early", 32'(rgwant_read), 32'd0);
    tick();
    checkOutput("read_raised", 32'(rgwant_read), 32'd1);
    repeat (4) tick();
    checkOutput("read_held", 32'(rgwant_read), 32'd1);
    applyStimulus(0, 0, 0, 1, 0, 0, 0, 0);
    tick();
    checkOutput("read_dropped", 32'(rgwant_read), 32'd0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    checkOutput("read_stays_low", 32'(rgwant_read), 32'd0);

    // Continuous offer on consumer 01: 8 busy, 1 free, repeating.
    assertReset();
    #2 reset = 1'b1;
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 0);
    for (int t = 1; t <= 27; t++) begin
      tick();
      checkOutput($sformatf("busy01_t%0d", t), 32'(busy01), 32'((t % 9) != 0));
    end
    checkOutput("busy10_idle", 32'(busy10), 32'd0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

    // Six back-to-back results: one dropped, five pulses 13 cycles apart.
    assertReset();
    #2 reset = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
    repeat (5) tick();
    checkOutput("ovf_before_full", 32'(result_ovf), 32'd0);
    tick();
    checkOutput("ovf_on_drop", 32'(result_ovf), 32'd1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (7) tick();
    checkOutput("result_early", 32'(rgResultReady), 32'd0);
    tick();
    checkOutput("result_first", 32'(rgResultReady), 32'd1);
    repeat (52) tick();
    checkOutput("result_last", 32'(rgResultReady), 32'd1);
    checkOutput("done_while_busy", 32'(rgDone), 32'd0);
    tick();
    checkOutput("done_after_drain", 32'(rgDone), 32'd1);
    repeat (20) tick();
    checkOutput("result_count", 32'(resCnt), 32'd5);
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("result_src%0d", i), 32'(srcLog[i]), (i % 2 == 0) ? 32'd1 : 32'd2);
    end
    checkOutput("ovf_sticky", 32'(result_ovf), 32'd1);

    // 32 beats give one scanline pulse; then reset aborts a pending ack.
    assertReset();
    #2 reset = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
    repeat (31) tick();
    checkOutput("scan_early", 32'(fbnextscanline), 32'd0);
    tick();
    checkOutput("scan_pulse", 32'(fbnextscanline), 32'd1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    checkOutput("scan_width", 32'(fbnextscanline), 32'd0);
    repeat (10) tick();
    checkOutput("scan_count", 32'(scanCnt), 32'd1);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    reset = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    clearCounts();
    #2;
    checkAllIdle("midwait_rst");
    #2 reset = 1'b1;
    repeat (10) tick();
    checkOutput("no_stray_ack", 32'(addrCnt + dataCnt + cfgCnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
